exm: RTL and testbench
======================

// Module: exm
// PURPOSE
//  Execute stage: takes one decoded instruction per accepted handshake, computes the ALU result and
//  branch decision, and builds the load/store request (address, byte lanes, aligned store data)
//  consumed by the load-store stage. It is the single pipeline register between decode and load-store.
//  It is also the only source of branch redirects to fetch.
// PARAMETERS
//  RESET_PC_OFFSET  0  reserved; must stay 0 (keeps parameter list stable for the core top)
// PORTS
//  clk_i            in   1   core clock
//  rst_i            in   1   asynchronous active-high reset
//  input_valid_i    in   1   decode holds a valid instruction
//  input_ready_o    out  1   exm accepts this cycle; = output_ready_i | ~output_valid_o (combinational)
//  pc_i             in   32  pc of instruction
//  alu_operand1_i   in   32  rs1 or pc
//  alu_operand2_i   in   32  rs2 or immediate
//  alu_op_i         in   3   alu_op_t: ADD,XOR,OR,AND,SLT,SLTU,SLL,SRL
//  alu_sub_i        in   1   ADD performs subtract
//  alu_arith_i      in   1   SRL performs arithmetic shift
//  branch_cond_i    in   3   branch_cond_t: NONE,BEQ,BNE,BLT,BGE,BLTU,BGEU,JUMP
//  branch_offset_i  in   32  signed offset; target = pc_i+offset (JUMP with jalr_i: (op1+offset)&~1)
//  jalr_i           in   1   JUMP is register-relative
//  ls_enable_i      in   1   instruction is a load/store
//  ls_write_i       in   1   store
//  ls_width_i       in   2   ls_width_t: BYTE,HALF,WORD
//  ls_data_i        in   32  store data (rs2, right-aligned)
//  ls_base_i        in   32  rs1 for address; address = ls_base_i + alu_operand2_i
//  reg_write_i      in   1   writes rd
//  reg_addr_i       in   5   rd
//  output_valid_o   out  1   registered result valid toward load-store
//  output_ready_i   in   1   load-store input_ready
//  alu_result_o     out  32  ALU result, or memory address when enable_o
//  enable_o         out  1   memory request
//  write_o          out  1   store
//  write_data_o     out  32  store data shifted into byte lanes
//  sel_o            out  4   byte-lane select
//  reg_write_o      out  1   rd write (JUMP writes pc_i+4 in alu_result_o)
//  reg_addr_o       out  5   rd
//  branch_o         out  1   one-cycle redirect pulse
//  branch_target_o  out  32  redirect pc
//  misaligned_o     out  1   one-cycle pulse: misaligned load/store squashed
// BEHAVIOUR
//  - Reset: every output 0 (input_ready_o then 1 as output_valid_o=0). Reset mid-transfer drops the instruction.
//  - Accept = input_valid_i & input_ready_o. On accept all outputs load next cycle; latency 1 cycle.
//  - Hold: output_valid_o & ~output_ready_i -> all output registers frozen, input_ready_o=0.
//  - No accept & output consumed -> output_valid_o falls to 0; reg_write_o/enable_o don't matter when invalid.
//  - ALU: 32-bit wrap; shifts use operand2[4:0]; SLT signed, SLTU unsigned; result 0/1.
//  - Branch: taken evaluated on accept; branch_o=1 and branch_target_o for exactly one cycle after.
//  - Squash: instruction accepted in a cycle where branch_o=1 is consumed but output_valid_o stays 0.
//  - Address a=ls_base_i+alu_operand2_i. BYTE: sel=1<<a[1:0]; HALF: sel=3<<a[1:0], a[0] must be 0;
//    WORD: sel=F, a[1:0] must be 00. write_data_o = ls_data_i << (8*a[1:0]).
//  - Misaligned: enable_o=0, reg_write_o=0, output_valid_o=1 (slot passes as bubble), misaligned_o pulse.
//  - Simultaneous hold and branch pulse: branch_o still lasts one cycle only.
// STRUCTURE
//  - ecap5_dproc_pkg: alu_op_t, branch_cond_t, ls_width_t enums and their encodings.
//  - Sub-module: alu (pure combinational ALU); exm holds the handshake, branch unit, lane logic, regs.
// TESTING
//  - Reset asserted mid-hold -> next cycle output_valid_o=0, branch_o=0, input_ready_o=1.
//  - ADD 0xFFFFFFFF+1 -> alu_result_o=0; SRL arith 0x80000000>>4 -> 0xF8000000; SLTU 1<0xFFFFFFFF -> 1.
//  - BYTE store 0xAB at base 0x1000, off 3 -> alu_result_o=0x1003, sel_o=0x8, write_data_o=0xAB000000.
//  - HALF load at 0x1001 -> misaligned_o=1, enable_o=0, output_valid_o=1.
//  - BEQ 5==5, pc 0x100, off -8 -> branch_o=1 one cycle, target 0xF8; next accepted instr squashed.
//  - output_ready_i=0 for 3 cycles with input_valid_i=1 -> outputs stable, input_ready_o=0, no loss.

Source files
------------

// File: rtl/ecap5_dproc_pkg.sv
// Shared encodings for the decode -> execute -> load-store path.
package ecap5_dproc_pkg;

  typedef enum logic [2:0] {
    AluAdd  = 3'd0,
    AluXor  = 3'd1,
    AluOr   = 3'd2,
    AluAnd  = 3'd3,
    AluSlt  = 3'd4,
    AluSltu = 3'd5,
    AluSll  = 3'd6,
    AluSrl  = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    BrNone = 3'd0,
    BrBeq  = 3'd1,
    BrBne  = 3'd2,
    BrBlt  = 3'd3,
    BrBge  = 3'd4,
    BrBltu = 3'd5,
    BrBgeu = 3'd6,
    BrJump = 3'd7
  } branch_cond_t;

  typedef enum logic [1:0] {
    LsByte = 2'd0,
    LsHalf = 2'd1,
    LsWord = 2'd2
  } ls_width_t;

endpackage

// File: rtl/exm_alu.sv
// Purely combinational integer ALU used by the execute stage.
module exm_alu
  import ecap5_dproc_pkg::*;
(
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [2:0]  op,
  input  logic        sub,
  input  logic        arith,
  output logic [31:0] result
);

  logic [4:0]  shamt;
  logic [31:0] sra;

  assign shamt = operand2[4:0];
  // Kept in its own signal so the arithmetic shift stays signed.
  assign sra   = $signed(operand1) >>> shamt;

  always_comb begin
    result = '0;
    unique case (alu_op_t'(op))
      AluAdd:  result = sub ? operand1 - operand2 : operand1 + operand2;
      AluXor:  result = operand1 ^ operand2;
      AluOr:   result = operand1 | operand2;
      AluAnd:  result = operand1 & operand2;
      AluSlt:  result = {31'd0, $signed(operand1) < $signed(operand2)};
      AluSltu: result = {31'd0, operand1 < operand2};
      AluSll:  result = operand1 << shamt;
      AluSrl:  result = arith ? sra : operand1 >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exm.sv
// Execute stage: ALU, branch resolution and load/store request build, registered once
// between decode and load-store with a valid/ready handshake.
module exm
  import ecap5_dproc_pkg::*;
#(
  parameter int unsigned RESET_PC_OFFSET = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_operand1_i,
  input  logic [31:0] alu_operand2_i,
  input  logic [2:0]  alu_op_i,
  input  logic        alu_sub_i,
  input  logic        alu_arith_i,
  input  logic [2:0]  branch_cond_i,
  input  logic [31:0] branch_offset_i,
  input  logic        jalr_i,
  input  logic        ls_enable_i,
  input  logic        ls_write_i,
  input  logic [1:0]  ls_width_i,
  input  logic [31:0] ls_data_i,
  input  logic [31:0] ls_base_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  output logic        output_valid_o,
  input  logic        output_ready_i,
  output logic [31:0] alu_result_o,
  output logic        enable_o,
  output logic        write_o,
  output logic [31:0] write_data_o,
  output logic [3:0]  sel_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic        branch_o,
  output logic [31:0] branch_target_o,
  output logic        misaligned_o
);

  logic        valid_q, valid_d, enable_q, enable_d, write_q, write_d;
  logic        reg_write_q, reg_write_d, branch_q, branch_d, misaligned_q, misaligned_d;
  logic [31:0] result_q, result_d, wdata_q, wdata_d, target_q, target_d;
  logic [3:0]  sel_q, sel_d;
  logic [4:0]  reg_addr_q, reg_addr_d;

  logic        accept, taken, misaligned, is_jump;
  logic [31:0] alu_out, ls_addr, target;
  logic [3:0]  sel;

  exm_alu u_alu (
    .operand1 (alu_operand1_i),
    .operand2 (alu_operand2_i),
    .op       (alu_op_i),
    .sub      (alu_sub_i),
    .arith    (alu_arith_i),
    .result   (alu_out)
  );

  assign input_ready_o = output_ready_i | ~valid_q;
  assign accept        = input_valid_i & input_ready_o;
  assign is_jump       = branch_cond_t'(branch_cond_i) == BrJump;
  assign ls_addr       = ls_base_i + alu_operand2_i;

  always_comb begin
    taken = 1'b0;
    unique case (branch_cond_t'(branch_cond_i))
      BrBeq:   taken = alu_operand1_i == alu_operand2_i;
      BrBne:   taken = alu_operand1_i != alu_operand2_i;
      BrBlt:   taken = $signed(alu_operand1_i) < $signed(alu_operand2_i);
      BrBge:   taken = $signed(alu_operand1_i) >= $signed(alu_operand2_i);
      BrBltu:  taken = alu_operand1_i < alu_operand2_i;
      BrBgeu:  taken = alu_operand1_i >= alu_operand2_i;
      BrJump:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    target = (is_jump && jalr_i) ? (alu_operand1_i + branch_offset_i) & ~32'd1
                                 : pc_i + branch_offset_i;
  end

  always_comb begin
    misaligned = 1'b0;
    sel        = 4'h0;
    unique case (ls_width_t'(ls_width_i))
      LsByte: sel = 4'b0001 << ls_addr[1:0];
      LsHalf: begin
        sel        = 4'b0011 << ls_addr[1:0];
        misaligned = ls_addr[0];
      end
      default: begin
        sel        = 4'hF;
        misaligned = |ls_addr[1:0];
      end
    endcase
    if (!ls_enable_i) begin
      misaligned = 1'b0;
      sel        = 4'h0;
    end
  end

  // Registers hold while stalled; only the two pulse outputs self-clear every cycle.
  always_comb begin
    valid_d      = valid_q;
    result_d     = result_q;
    enable_d     = enable_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    reg_write_d  = reg_write_q;
    reg_addr_d   = reg_addr_q;
    target_d     = target_q;
    branch_d     = 1'b0;
    misaligned_d = 1'b0;
    if (accept) begin
      // The slot right behind a taken branch is the wrong path: consume it as a bubble.
      valid_d      = ~branch_q;
      result_d     = is_jump ? pc_i + 32'd4 : (ls_enable_i ? ls_addr : alu_out);
      enable_d     = ls_enable_i & ~misaligned;
      write_d      = ls_enable_i & ls_write_i & ~misaligned;
      wdata_d      = ls_data_i << {ls_addr[1:0], 3'b000};
      sel_d        = sel;
      reg_write_d  = reg_write_i & ~misaligned;
      reg_addr_d   = reg_addr_i;
      branch_d     = taken & ~branch_q;
      target_d     = target;
      misaligned_d = misaligned & ~branch_q;
    end else if (input_ready_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      result_q     <= '0;
      enable_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      sel_q        <= '0;
      reg_write_q  <= 1'b0;
      reg_addr_q   <= '0;
      branch_q     <= 1'b0;
      target_q     <= 32'(RESET_PC_OFFSET);
      misaligned_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      result_q     <= result_d;
      enable_q     <= enable_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      reg_write_q  <= reg_write_d;
      reg_addr_q   <= reg_addr_d;
      branch_q     <= branch_d;
      target_q     <= target_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign output_valid_o  = valid_q;
  assign alu_result_o    = result_q;
  assign enable_o        = enable_q;
  assign write_o         = write_q;
  assign write_data_o    = wdata_q;
  assign sel_o           = sel_q;
  assign reg_write_o     = reg_write_q;
  assign reg_addr_o      = reg_addr_q;
  assign branch_o        = branch_q;
  assign branch_target_o = target_q;
  assign misaligned_o    = misaligned_q;

endmodule

// File: tb/tb_exm.sv
// Bench for exm: directed corner cases plus random traffic against a behavioural model.
module tb_exm;
  import ecap5_dproc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        input_valid_i = 1'b0, output_ready_i = 1'b0;
  logic [31:0] pc_i, alu_operand1_i, alu_operand2_i, branch_offset_i, ls_data_i, ls_base_i;
  logic [2:0]  alu_op_i, branch_cond_i;
  logic        alu_sub_i, alu_arith_i, jalr_i, ls_enable_i, ls_write_i, reg_write_i;
  logic [1:0]  ls_width_i;
  logic [4:0]  reg_addr_i;

  logic        input_ready_o, output_valid_o, enable_o, write_o, reg_write_o;
  logic        branch_o, misaligned_o;
  logic [31:0] alu_result_o, write_data_o, branch_target_o;
  logic [3:0]  sel_o;
  logic [4:0]  reg_addr_o;

  always #5 clk = ~clk;

  exm dut (
    .clk_i(clk), .rst_i(rst), .input_valid_i(input_valid_i), .input_ready_o(input_ready_o),
    .pc_i(pc_i), .alu_operand1_i(alu_operand1_i), .alu_operand2_i(alu_operand2_i),
    .alu_op_i(alu_op_i), .alu_sub_i(alu_sub_i), .alu_arith_i(alu_arith_i),
    .branch_cond_i(branch_cond_i), .branch_offset_i(branch_offset_i), .jalr_i(jalr_i),
    .ls_enable_i(ls_enable_i), .ls_write_i(ls_write_i), .ls_width_i(ls_width_i),
    .ls_data_i(ls_data_i), .ls_base_i(ls_base_i), .reg_write_i(reg_write_i),
    .reg_addr_i(reg_addr_i), .output_valid_o(output_valid_o), .output_ready_i(output_ready_i),
    .alu_result_o(alu_result_o), .enable_o(enable_o), .write_o(write_o),
    .write_data_o(write_data_o), .sel_o(sel_o), .reg_write_o(reg_write_o),
    .reg_addr_o(reg_addr_o), .branch_o(branch_o), .branch_target_o(branch_target_o),
    .misaligned_o(misaligned_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected register contents of the stage.
  logic        m_valid, m_enable, m_write, m_rw, m_branch, m_mis;
  logic [31:0] m_result, m_wdata, m_target;
  logic [3:0]  m_sel;
  logic [4:0]  m_raddr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic sub,
                                          input logic arith, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    longint sa, sb;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return sub ? a - b : a + b;
      3'd1: return a ^ b;
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: return (sa < sb) ? 32'd1 : 32'd0;
      3'd5: return (a < b) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      default: begin
        if (arith) return 32'(sa >>> sh);
        return a >> sh;
      end
    endcase
  endfunction

  function automatic logic taken_ref(input logic [2:0] c, input logic [31:0] a,
                                     input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return sa < sb;
      3'd4: return sa >= sb;
      3'd5: return a < b;
      3'd6: return a >= b;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_enable = 0; m_write = 0; m_rw = 0; m_branch = 0; m_mis = 0;
    m_result = 0; m_wdata = 0; m_target = 0; m_sel = 0; m_raddr = 0;
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1 after checking.
  task automatic step();
    logic        rdy, acc, aligned, mis;
    logic [31:0] addr;
    int          lo;
    logic        n_valid, n_enable, n_write, n_rw, n_branch, n_mis;
    logic [31:0] n_result, n_wdata, n_target;
    logic [3:0]  n_sel;
    logic [4:0]  n_raddr;
    #1;
    rdy = output_ready_i | ~m_valid;
    check_eq("input_ready", 32'(input_ready_o), 32'(rdy));
    acc = input_valid_i & rdy;
    n_valid = m_valid; n_enable = m_enable; n_write = m_write; n_rw = m_rw;
    n_result = m_result; n_wdata = m_wdata; n_target = m_target; n_sel = m_sel;
    n_raddr = m_raddr; n_branch = 0; n_mis = 0;
    if (acc) begin
      addr = ls_base_i + alu_operand2_i;
      lo = int'(addr % 4);
      case (ls_width_i)
        2'd0: begin n_sel = 4'(1 << lo); aligned = 1'b1; end
        2'd1: begin n_sel = 4'(3 << lo); aligned = (lo % 2) == 0; end
        default: begin n_sel = 4'hF; aligned = lo == 0; end
      endcase
      mis = ls_enable_i && !aligned;
      n_valid = !m_branch;
      if (branch_cond_i == 3'd7) n_result = pc_i + 4;
      else if (ls_enable_i) n_result = addr;
      else n_result = alu_ref(alu_op_i, alu_sub_i, alu_arith_i, alu_operand1_i, alu_operand2_i);
      n_enable = ls_enable_i && !mis;
      n_write  = n_enable && ls_write_i;
      n_wdata  = ls_data_i << (8 * lo);
      n_rw     = reg_write_i && !mis;
      n_raddr  = reg_addr_i;
      n_branch = taken_ref(branch_cond_i, alu_operand1_i, alu_operand2_i) && !m_branch;
      n_target = (branch_cond_i == 3'd7 && jalr_i) ?
                 (alu_operand1_i + branch_offset_i) & 32'hFFFF_FFFE : pc_i + branch_offset_i;
      n_mis    = mis && !m_branch;
    end else if (rdy) begin
      n_valid = 0;
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_enable = n_enable; m_write = n_write; m_rw = n_rw;
    m_result = n_result; m_wdata = n_wdata; m_target = n_target; m_sel = n_sel;
    m_raddr = n_raddr; m_branch = n_branch; m_mis = n_mis;
    check_eq("output_valid", 32'(output_valid_o), 32'(m_valid));
    check_eq("branch", 32'(branch_o), 32'(m_branch));
    check_eq("misaligned", 32'(misaligned_o), 32'(m_mis));
    if (m_branch) check_eq("branch_target", branch_target_o, m_target);
    if (m_valid) begin
      check_eq("alu_result", alu_result_o, m_result);
      check_eq("reg_write", 32'(reg_write_o), 32'(m_rw));
      check_eq("reg_addr", 32'(reg_addr_o), 32'(m_raddr));
      check_eq("enable", 32'(enable_o), 32'(m_enable));
      if (m_enable) begin
        check_eq("write", 32'(write_o), 32'(m_write));
        check_eq("sel", 32'(sel_o), 32'(m_sel));
        check_eq("write_data", write_data_o, m_wdata);
      end
    end
  endtask

  task automatic clear_instr();
    pc_i = 0; alu_operand1_i = 0; alu_operand2_i = 0; alu_op_i = 0; alu_sub_i = 0;
    alu_arith_i = 0; branch_cond_i = 0; branch_offset_i = 0; jalr_i = 0; ls_enable_i = 0;
    ls_write_i = 0; ls_width_i = 0; ls_data_i = 0; ls_base_i = 0; reg_write_i = 0;
    reg_addr_i = 0;
  endtask

  task automatic rand_instr();
    pc_i            = $urandom() & 32'hFFFF_FFFC;
    alu_operand1_i  = $urandom();
    alu_operand2_i  = ($urandom_range(0, 2) == 0) ? alu_operand1_i :
                      ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 40));
    alu_op_i        = 3'($urandom_range(0, 7));
    alu_sub_i       = 1'($urandom_range(0, 1));
    alu_arith_i     = 1'($urandom_range(0, 1));
    branch_cond_i   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    branch_offset_i = $urandom();
    jalr_i          = 1'($urandom_range(0, 1));
    ls_enable_i     = $urandom_range(0, 2) == 0;
    ls_write_i      = 1'($urandom_range(0, 1));
    ls_width_i      = 2'($urandom_range(0, 2));
    ls_data_i       = $urandom();
    ls_base_i       = $urandom();
    reg_write_i     = 1'($urandom_range(0, 1));
    reg_addr_i      = 5'($urandom_range(0, 31));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, 32'(output_valid_o), 32'd0);
    check_eq({tag, "_branch"}, 32'(branch_o), 32'd0);
    check_eq({tag, "_ready"}, 32'(input_ready_o), 32'd1);
    check_eq({tag, "_result"}, alu_result_o, 32'd0);
    check_eq({tag, "_sel"}, 32'(sel_o), 32'd0);
  endtask

  initial begin
    clear_instr();
    model_reset();
    @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    output_ready_i = 1'b1;
    input_valid_i  = 1'b1;

    // 32-bit wrap on ADD.
    clear_instr(); alu_operand1_i = 32'hFFFF_FFFF; alu_operand2_i = 32'd1;
    alu_op_i = AluAdd; reg_write_i = 1; reg_addr_i = 5'd3;
    step();
    check_eq("add_wrap", alu_result_o, 32'd0);

    clear_instr(); alu_operand1_i = 32'h8000_0000; alu_operand2_i = 32'd4;
    alu_op_i = AluSrl; alu_arith_i = 1;
    step();
    check_eq("sra", alu_result_o, 32'hF800_0000);

    clear_instr(); alu_operand1_i = 32'd1; alu_operand2_i = 32'hFFFF_FFFF; alu_op_i = AluSltu;
    step();
    check_eq("sltu", alu_result_o, 32'd1);

    clear_instr(); ls_enable_i = 1; ls_write_i = 1; ls_width_i = LsByte;
    ls_base_i = 32'h1000; alu_operand2_i = 32'd3; ls_data_i = 32'h0000_00AB;
    step();
    check_eq("sb_addr", alu_result_o, 32'h1003);
    check_eq("sb_sel", 32'(sel_o), 32'h8);
    check_eq("sb_data", write_data_o, 32'hAB00_0000);

    clear_instr(); ls_enable_i = 1; ls_width_i = LsHalf; ls_base_i = 32'h1000;
    alu_operand2_i = 32'd1; reg_write_i = 1; reg_addr_i = 5'd7;
    step();
    check_eq("lh_mis", 32'(misaligned_o), 32'd1);
    check_eq("lh_enable", 32'(enable_o), 32'd0);
    check_eq("lh_valid", 32'(output_valid_o), 32'd1);
    check_eq("lh_regwr", 32'(reg_write_o), 32'd0);

    // Taken BEQ, then the following instruction must be squashed.
    clear_instr(); branch_cond_i = BrBeq; alu_operand1_i = 32'd5; alu_operand2_i = 32'd5;
    pc_i = 32'h100; branch_offset_i = 32'hFFFF_FFF8;
    step();
    check_eq("beq_branch", 32'(branch_o), 32'd1);
    check_eq("beq_target", branch_target_o, 32'h0000_00F8);
    clear_instr(); alu_operand1_i = 32'd9; alu_operand2_i = 32'd1; reg_write_i = 1;
    step();
    check_eq("squash_valid", 32'(output_valid_o), 32'd0);
    check_eq("branch_once", 32'(branch_o), 32'd0);

    // Back-pressure: three stalled cycles, then the waiting instruction must appear.
    clear_instr(); alu_operand1_i = 32'd1; alu_operand2_i = 32'd2;
    step();
    clear_instr(); alu_operand1_i = 32'h40; alu_operand2_i = 32'h2; alu_op_i = AluOr;
    output_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_result", alu_result_o, 32'd3);
      check_eq("hold_ready", 32'(input_ready_o), 32'd0);
    end
    output_ready_i = 1'b1;
    step();
    check_eq("hold_release", alu_result_o, 32'h42);

    // Reset while held with a taken branch in flight.
    clear_instr(); branch_cond_i = BrJump; pc_i = 32'h200; branch_offset_i = 32'h10;
    step();
    output_ready_i = 1'b0;
    step();
    rst = 1'b1;
    #2;
    check_reset_state("rst_hold_async");
    @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    rst = 1'b0;
    model_reset();

    for (int n = 0; n < 800; n++) begin
      input_valid_i  = $urandom_range(0, 3) != 0;
      output_ready_i = $urandom_range(0, 3) != 0;
      rand_instr();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
